// File: rtl/moore_seq_detector_param.sv
// -----------------------------------------------------------------------------
// moore_seq_detector_param
//
// Parametrised Moore sequence detector. A serial bit stream (din, qualified by
// din_en) is shifted into a PATTERN_W-bit history register and compared against
// a runtime-programmable pattern. Overlapping or non-overlapping matching is
// selected at runtime. Each match produces a one-cycle dout pulse decoded from
// the state register only, so there is no combinational path from din to dout.
//
// Optional feature (compile-time macro MATCH_COUNT_EN):
//   defined   - match_count is a saturating count of matches, cleared by reset
//               only (clear does not touch it).
//   undefined - no counter is built and match_count is tied to 0.
//
// Parameters:
//   PATTERN_W  pattern length in bits (2..16)
//   CNT_W      match counter width
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset (0 = reset asserted)
//   din          in   serial data bit
//   din_en       in   din is accepted only on edges where din_en=1
//   pattern      in   target sequence, pattern[PATTERN_W-1] is received first;
//                     must be held stable during detection
//   overlap      in   1 = overlapping matches, 0 = non-overlapping
//   clear        in   synchronous restart of detection (wins over din_en)
//   dout         out  Moore match flag, high one cycle per match
//   match_count  out  saturating match count (0 when MATCH_COUNT_EN undefined)
// -----------------------------------------------------------------------------
module moore_seq_detector_param #(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    input  logic                 din_en,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic                 overlap,
    input  logic                 clear,
    output logic                 dout,
    output logic [CNT_W-1:0]     match_count
);

    // fill counts valid history bits and saturates at PATTERN_W.
    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    typedef enum logic [1:0] {
        FILL  = 2'd0,   // fewer than PATTERN_W valid bits held
        ARMED = 2'd1,   // window full, last compare failed
        HIT   = 2'd2    // a match completed on the previous edge
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [PATTERN_W-1:0]   hist;
    logic [PATTERN_W-1:0]   hist_n;
    logic [FILL_W-1:0]      fill;
    logic [FILL_W-1:0]      fill_n;

    // Candidate values if the current din is accepted on this edge.
    logic [PATTERN_W-1:0]   hist_shift;
    logic [FILL_W-1:0]      fill_inc;
    logic                   window_full;
    logic                   window_match;
    logic                   accept;
    logic                   enter_hit;

    assign hist_shift   = {hist[PATTERN_W-2:0], din};
    assign fill_inc     = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    assign window_full  = (fill_inc == FILL_FULL);
    assign window_match = window_full && (hist_shift == pattern);

    // clear has priority: a bit presented together with clear is dropped.
    assign accept       = din_en && !clear;
    assign enter_hit    = accept && window_match;

    // -------------------------------------------------------------------------
    // Process 1: state register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of process ordering.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            hist  <= '0;
            fill  <= '0;
        end else begin
            state <= state_n;
            hist  <= hist_n;
            fill  <= fill_n;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic.
    // NOTE: every signal gets a hold/default value before any branch, so no
    // path through the block leaves an output unassigned and no latch appears.
    // -------------------------------------------------------------------------
    always_comb begin
        state_n = state;
        hist_n  = hist;
        fill_n  = fill;

        if (clear) begin
            // Restart: the history bits stay put but are ignored until refilled.
            state_n = FILL;
            fill_n  = '0;
        end else if (accept) begin
            hist_n = hist_shift;
            if (enter_hit) begin
                state_n = HIT;
                // Non-overlap needs PATTERN_W fresh bits before the next match;
                // overlap keeps the window full so every bit can end a match.
                fill_n  = overlap ? FILL_FULL : '0;
            end else begin
                state_n = window_full ? ARMED : FILL;
                fill_n  = fill_inc;
            end
        end else if (state == HIT) begin
            // HIT never lasts longer than one cycle without a new match.
            state_n = (fill == FILL_FULL) ? ARMED : FILL;
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: Moore output decode, from the state register only.
    // -------------------------------------------------------------------------
    always_comb begin
        dout = (state == HIT);
    end

    // -------------------------------------------------------------------------
    // Optional saturating match counter. Counts every entry into HIT, including
    // HIT->HIT on back-to-back overlapping matches.
    // -------------------------------------------------------------------------
`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // NOTE: only control/state registers need reset; this counter is reset
    // because its value is architecturally visible from the first cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enter_hit && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_detector_param
//
// Self-checking bench for moore_seq_detector_param. Two instances share the
// inputs: one with the default counter width and one with CNT_W=2 to exercise
// saturation. A behavioural model keeps the accepted bits since the last
// restart in a queue and declares a match whenever the newest PATTERN_W bits
// equal the pattern. Directed sequences pin the model with literal pulse masks.
// -----------------------------------------------------------------------------
module tb_moore_seq_detector_param;

    localparam int W         = 4;
    localparam int CNT_W     = 8;
    localparam int CNT_W_SAT = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int CNT_MAX_SAT = (1 << CNT_W_SAT) - 1;

`ifdef MATCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk     = 1'b0;
    logic                 reset   = 1'b0;
    logic                 din     = 1'b0;
    logic                 din_en  = 1'b0;
    logic [W-1:0]         pattern = '0;
    logic                 overlap = 1'b0;
    logic                 clear   = 1'b0;
    logic                 dout;
    logic [CNT_W-1:0]     match_count;
    logic                 dout_sat;
    logic [CNT_W_SAT-1:0] match_count_sat;

    moore_seq_detector_param #(.PATTERN_W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_en      (din_en),
        .pattern     (pattern),
        .overlap     (overlap),
        .clear       (clear),
        .dout        (dout),
        .match_count (match_count)
    );

    moore_seq_detector_param #(.PATTERN_W(W), .CNT_W(CNT_W_SAT)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_en      (din_en),
        .pattern     (pattern),
        .overlap     (overlap),
        .clear       (clear),
        .dout        (dout_sat),
        .match_count (match_count_sat)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------- model
    bit q[$];          // accepted bits since the last restart, newest at back
    bit exp_dout = 1'b0;
    int exp_cnt  = 0;
    int exp_cnt_sat = 0;

    function automatic bit newest_bits_match();
        int base;
        if (q.size() < W) return 1'b0;
        base = q.size() - W;
        for (int k = 0; k < W; k++) begin
            if (q[base + k] != pattern[W-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_dout    = 1'b0;
        exp_cnt     = 0;
        exp_cnt_sat = 0;
    endtask

    // Applies the rules for one rising edge, using the inputs held across it.
    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else if (clear) begin
            q.delete();
            exp_dout = 1'b0;
        end else if (din_en) begin
            q.push_back(din);
            if (q.size() > W) void'(q.pop_front());
            exp_dout = newest_bits_match();
            if (exp_dout) begin
                if (exp_cnt < CNT_MAX) exp_cnt++;
                if (exp_cnt_sat < CNT_MAX_SAT) exp_cnt_sat++;
                if (!overlap) q.delete();
            end
        end else begin
            exp_dout = 1'b0;
        end
    endtask

    // One compare process: outputs checked every falling edge.
    always @(negedge clk) begin
        check("dout", 32'(dout), 32'(exp_dout));
        check("dout_sat", 32'(dout_sat), 32'(exp_dout));
        check("match_count", 32'(match_count), CNT_EN ? 32'(exp_cnt) : 32'd0);
        check("match_count_sat", 32'(match_count_sat),
              CNT_EN ? 32'(exp_cnt_sat) : 32'd0);
    end

    // ---------------------------------------------------------------- stimulus
    // Inputs change 1 time unit after a rising edge, are held across the next
    // rising edge, and the model is advanced right at that edge.
    task automatic tick(input logic b, input logic en, input logic clr);
        din    = b;
        din_en = en;
        clear  = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        repeat (cycles) tick(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // Sends n accepted bits (bits[0] first) with 'gaps' idle cycles between
    // them; mask[i] is dout after bit i, gap_high counts dout highs in gaps.
    task automatic send_bits(input logic [15:0] bits, input int n, input int gaps,
                             output logic [15:0] mask, output int gap_high);
        mask     = '0;
        gap_high = 0;
        for (int i = 0; i < n; i++) begin
            tick(bits[i], 1'b1, 1'b0);
            mask[i] = dout;
            if (i < n - 1) begin
                for (int g = 0; g < gaps; g++) begin
                    tick(1'b0, 1'b0, 1'b0);
                    gap_high += int'(dout);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] mask;
        int          gh;

        // --- reset held with din=1 streaming in
        reset   = 1'b0;
        pattern = 4'b1001;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            check("reset_dout", 32'(dout), 32'd0);
            check("reset_count", 32'(match_count), 32'd0);
        end
        reset = 1'b1;

        // --- reset asserted after 3 of 4 pattern bits
        send_bits(16'b0001, 3, 0, mask, gh);
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset_dout", 32'(dout), 32'd0);
        #2;
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        check("reset_midseq_no_hit", 32'(dout), 32'd0);

        // --- non-overlap, stream 1,1,0,0,1,0,0,1,0,0,1
        do_reset(2);
        overlap = 1'b0;
        send_bits(16'h0493, 11, 0, mask, gh);
        check("nonoverlap_mask", 32'(mask[10:0]), 32'h410);
        check("nonoverlap_count", 32'(match_count), CNT_EN ? 32'd2 : 32'd0);

        // --- overlap, same stream
        do_reset(2);
        overlap = 1'b1;
        send_bits(16'h0493, 11, 0, mask, gh);
        check("overlap_mask", 32'(mask[10:0]), 32'h490);
        check("overlap_count", 32'(match_count), CNT_EN ? 32'd3 : 32'd0);

        // --- back-to-back, pattern 1111, ten 1s
        do_reset(2);
        pattern = 4'b1111;
        overlap = 1'b1;
        send_bits(16'h03FF, 10, 0, mask, gh);
        check("b2b_overlap_mask", 32'(mask[9:0]), 32'h3F8);
        check("b2b_overlap_count", 32'(match_count), CNT_EN ? 32'd7 : 32'd0);
        check("sat_count", 32'(match_count_sat), CNT_EN ? 32'd3 : 32'd0);
        check("model_sat_count", 32'(exp_cnt_sat), 32'd3);

        do_reset(2);
        overlap = 1'b0;
        send_bits(16'h03FF, 10, 0, mask, gh);
        check("b2b_nonoverlap_mask", 32'(mask[9:0]), 32'h088);

        // --- five overlapping matches saturate the 2-bit counter at 3
        do_reset(2);
        overlap = 1'b1;
        send_bits(16'h00FF, 8, 0, mask, gh);
        check("sat5_mask", 32'(mask[7:0]), 32'hF8);
        check("sat5_count_sat", 32'(match_count_sat), CNT_EN ? 32'd3 : 32'd0);
        check("sat5_count", 32'(match_count), CNT_EN ? 32'd5 : 32'd0);

        // --- enable gaps: 1,0,0,1 with two idle cycles between bits
        do_reset(2);
        pattern = 4'b1001;
        overlap = 1'b0;
        send_bits(16'h0009, 4, 2, mask, gh);
        check("gaps_mask", 32'(mask[3:0]), 32'h8);
        check("gaps_dout_low", 32'(gh), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check("hit_one_cycle", 32'(dout), 32'd0);

        // --- clear coincident with the last bit, then a full pattern
        do_reset(2);
        send_bits(16'h0001, 3, 0, mask, gh);
        tick(1'b1, 1'b1, 1'b1);
        check("clear_drops_bit", 32'(dout), 32'd0);
        send_bits(16'h0009, 4, 0, mask, gh);
        check("after_clear_mask", 32'(mask[3:0]), 32'h8);

        // --- randomized traffic checked by the compare process
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            logic clr;
            clr = 1'b0;
            if ($urandom_range(0, 99) < 3) begin
                pattern = W'($urandom);
                clr     = 1'b1;
            end
            if ($urandom_range(0, 99) < 2) overlap = ~overlap;
            if ($urandom_range(0, 999) < 4) begin
                reset = 1'b0;
                model_reset();
                #2;
                reset = 1'b1;
            end
            tick(1'($urandom), ($urandom_range(0, 3) != 0), clr);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
